// File: rtl/precharge_bus_if.sv
// Handshake bundle for the precharged bus model:
// precharge/driver requests in, registered node state out.
interface precharge_bus_if #(
  parameter int WIDTH = 8,
  parameter int NDRV  = 4,
  parameter int CNT_W = 5
);
  logic                  pre;
  logic [NDRV-1:0]       drv_en;
  logic [NDRV*WIDTH-1:0] drv_data;
  logic [WIDTH-1:0]      bus;
  logic                  bus_valid;
  logic                  decayed;
  logic                  contention;
  logic [CNT_W-1:0]      hold_cnt;

  modport master (
    output pre, drv_en, drv_data,
    input  bus, bus_valid, decayed,
    input  contention, hold_cnt
  );

  modport slave (
    input  pre, drv_en, drv_data,
    output bus, bus_valid, decayed,
    output contention, hold_cnt
  );
endinterface

// File: rtl/precharge_bus.sv
// Precharged internal bus with open-drain drivers,
// discharge-only evaluation and a charge-retention timer.
module precharge_bus #(
  parameter int WIDTH = 8,
  parameter int NDRV  = 4,
  parameter int DECAY = 16,
  parameter int CNT_W = 5
) (
  input logic             clk,
  input logic             rst_n,
  precharge_bus_if.slave  pb
);

  typedef enum logic [2:0] {
    UNCHARGED,
    PRECHARGED,
    EVAL,
    HOLD,
    DECAYED
  } state_t;

  localparam logic [CNT_W-1:0] DEC =
    CNT_W'(DECAY);

  state_t           st;
  logic [WIDTH-1:0] bus_q;
  logic             valid_q;
  logic             dec_q;
  logic             cont_q;
  logic [CNT_W-1:0] hold_q;

  logic [WIDTH-1:0] mask;
  logic [CNT_W-1:0] hold_nxt;
  logic             any_en;
  logic             dead;

  // wired-AND of every enabled pull-down channel
  always_comb begin
    mask = '1;
    for (int k = 0; k < NDRV; k++) begin
      if (pb.drv_en[k])
        mask &= pb.drv_data[k*WIDTH +: WIDTH];
    end
  end

  assign any_en   = |pb.drv_en;
  assign hold_nxt = hold_q + 1'b1;
  assign dead     = (st == UNCHARGED) ||
                    (st == DECAYED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= UNCHARGED;
      bus_q   <= '0;
      valid_q <= 1'b0;
      dec_q   <= 1'b0;
      cont_q  <= 1'b0;
      hold_q  <= '0;
    end else begin
      cont_q <= 1'b0;
      unique case (1'b1)
        pb.pre && any_en: begin
          bus_q   <= mask;
          st      <= EVAL;
          valid_q <= 1'b1;
          dec_q   <= 1'b0;
          hold_q  <= '0;
          cont_q  <= 1'b1;
        end
        pb.pre && !any_en: begin
          bus_q   <= '1;
          st      <= PRECHARGED;
          valid_q <= 1'b1;
          dec_q   <= 1'b0;
          hold_q  <= '0;
        end
        !pb.pre && any_en: begin
          hold_q <= '0;
          // no charge to discharge: node stays low
          if (dead) begin
            bus_q <= '0;
          end else begin
            bus_q <= bus_q & mask;
            st    <= EVAL;
          end
        end
        default: begin
          if (!dead) begin
            if (hold_nxt == DEC) begin
              bus_q   <= '0;
              valid_q <= 1'b0;
              dec_q   <= 1'b1;
              st      <= DECAYED;
              hold_q  <= DEC;
            end else begin
              st     <= HOLD;
              hold_q <= hold_nxt;
            end
          end
        end
      endcase
    end
  end

  assign pb.bus        = bus_q;
  assign pb.bus_valid  = valid_q;
  assign pb.decayed    = dec_q;
  assign pb.contention = cont_q;
  assign pb.hold_cnt   = hold_q;

endmodule

// File: tb/tb_precharge_bus.sv
// Directed bench for precharge_bus: precharge, evaluate,
// decay, contention, reset behaviour.
module tb_precharge_bus;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  precharge_bus_if #(
    .WIDTH(8), .NDRV(4), .CNT_W(5)
  ) pb ();

  precharge_bus #(
    .WIDTH(8), .NDRV(4),
    .DECAY(16), .CNT_W(5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .pb    (pb)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  task automatic cyc(
    input logic        p,
    input logic [3:0]  e,
    input logic [31:0] d
  );
    pb.pre      = p;
    pb.drv_en   = e;
    pb.drv_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 4'b0000, 32'h0);
  endtask

  initial begin
    pb.pre      = 1'b0;
    pb.drv_en   = '0;
    pb.drv_data = '0;
    #12;
    chk("rst_bus", pb.bus, 8'h00);
    chk("rst_valid", pb.bus_valid, 1'b0);
    chk("rst_dec", pb.decayed, 1'b0);
    chk("rst_cont", pb.contention, 1'b0);
    chk("rst_hold", pb.hold_cnt, 5'd0);
    rst_n = 1'b1;

    // plain precharge
    cyc(1'b1, 4'b0000, 32'h0);
    chk("pre_bus", pb.bus, 8'hFF);
    chk("pre_valid", pb.bus_valid, 1'b1);
    chk("pre_hold", pb.hold_cnt, 5'd0);
    chk("pre_cont", pb.contention, 1'b0);

    // cumulative discharge
    cyc(1'b0, 4'b0001, 32'h0000_00F0);
    chk("ev0_bus", pb.bus, 8'hF0);
    cyc(1'b0, 4'b0010, 32'h0000_3C00);
    chk("ev1_bus", pb.bus, 8'h30);
    cyc(1'b0, 4'b0001, 32'h0000_00FF);
    chk("ev2_bus", pb.bus, 8'h30);
    chk("ev2_hold", pb.hold_cnt, 5'd0);
    chk("ev2_valid", pb.bus_valid, 1'b1);

    // retention and decay
    cyc(1'b1, 4'b0000, 32'h0);
    for (int i = 1; i < 16; i++) begin
      idle();
      chk("hold_bus", pb.bus, 8'hFF);
      chk("hold_cnt", pb.hold_cnt, i);
    end
    chk("hold_valid", pb.bus_valid, 1'b1);
    chk("hold_dec", pb.decayed, 1'b0);
    idle();
    chk("dk_bus", pb.bus, 8'h00);
    chk("dk_dec", pb.decayed, 1'b1);
    chk("dk_valid", pb.bus_valid, 1'b0);
    chk("dk_hold", pb.hold_cnt, 5'd16);
    idle();
    chk("sat_hold", pb.hold_cnt, 5'd16);
    chk("sat_dec", pb.decayed, 1'b1);
    cyc(1'b1, 4'b0000, 32'h0);
    chk("rep_bus", pb.bus, 8'hFF);
    chk("rep_dec", pb.decayed, 1'b0);
    chk("rep_valid", pb.bus_valid, 1'b1);

    // precharge fighting drivers
    cyc(1'b1, 4'b0101, 32'h00FE_000F);
    chk("ct_bus", pb.bus, 8'h0E);
    chk("ct_cont", pb.contention, 1'b1);
    chk("ct_valid", pb.bus_valid, 1'b1);
    idle();
    chk("ct_cont0", pb.contention, 1'b0);
    chk("ct_bus2", pb.bus, 8'h0E);
    chk("ct_hold", pb.hold_cnt, 5'd1);

    // driving with no charge
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    cyc(1'b0, 4'b0001, 32'h0000_0000);
    chk("nc_bus", pb.bus, 8'h00);
    chk("nc_valid", pb.bus_valid, 1'b0);
    cyc(1'b0, 4'b0001, 32'h0000_00FF);
    chk("nc_bus2", pb.bus, 8'h00);

    // async reset in mid-hold
    cyc(1'b1, 4'b0000, 32'h0);
    cyc(1'b0, 4'b0001, 32'h0000_005A);
    for (int i = 0; i < 7; i++) idle();
    chk("mh_bus", pb.bus, 8'h5A);
    chk("mh_hold", pb.hold_cnt, 5'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_bus", pb.bus, 8'h00);
    chk("ar_valid", pb.bus_valid, 1'b0);
    chk("ar_hold", pb.hold_cnt, 5'd0);
    chk("ar_dec", pb.decayed, 1'b0);
    #2;
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
